board_move_collector: RTL and testbench
=======================================

// Module: board_move_collector
// PURPOSE
//  Downstream of the eight per-column move FIFOs. Drains them round-robin and unpacks each 160-bit word into 19-bit moves.
//  Emits the moves one at a time on a valid/ready stream to the search/eval stage.
//  Counts the moves and raises done once every column is done and fully drained.
// PARAMETERS
//  NCOL    8    number of column units / FIFOs serviced
//  WORD_W  160  column FIFO word width
//  MOVE_W  19   move width: [18:12] flags {invalid,promote,pawn,pawn2,ep,castle,capture}, [11:6] from, [5:0] to
//  SLOTS   8    move slots per word; slot k = word[k*19+18 : k*19], bits [159:152] ignored
// PORTS
//  clk         in   1          clock
//  reset       in   1          reset, synchronous, active-high
//  col_done    in   NCOL       per-column done (column state DONE)
//  col_empty   in   NCOL       per-column FIFO empty
//  col_data    in   NCOL*160   FIFO q buses; column c at [c*160+159 : c*160]
//  col_rden    out  NCOL       FIFO read enables, one-hot or zero
//  move_out    out  19         current move
//  move_valid  out  1          move_out valid
//  move_ready  in   1          consumer accepts move when valid&ready
//  move_count  out  8          moves accepted since reset, saturates at 255
//  done        out  1          all columns done, drained, last move accepted; sticky
// BEHAVIOUR
//  Reset: col_rden=0, move_valid=0, move_out=0, move_count=0, done=0, rr_ptr=0, state=SCAN. Reset overrides any state, including mid-unpack.
//  FIFO read is non-show-ahead: q is valid in the cycle after the rdreq cycle.
//  States:
//   SCAN: pick first c from rr_ptr upward (wrap 7->0) with col_empty[c]=0.
//     Assert col_rden[c] for exactly 1 cycle, latch sel=c, go to WAIT.
//     If no such c: go to DONE only when &col_done && &col_empty for 2 consecutive SCAN cycles. This covers the registered-wren lag in the column.
//   WAIT: 1 cycle. Capture col_data[sel] into word_r, set slot=0, go to UNPACK.
//   UNPACK: examine slot k each cycle.
//     If word_r slot k bit18 (invalid)=1: skip, no output cycle spent.
//     Else present the move, with move_valid=1, until move_ready. Hold move_out stable while valid&!ready.
//     On accept: move_count+1 (saturating), advance k.
//     After k=7, or when all remaining slots are invalid: rr_ptr=sel+1 (mod 8), return to SCAN.
//     An all-invalid word returns to SCAN after 1 cycle with no output.
//   DONE: done=1, col_rden=0, move_valid=0. Stays here until reset.
//  Only one FIFO read is outstanding at a time. Never assert col_rden[c] when col_empty[c]=1.
//  A column with col_done=1 but non-empty FIFO is still drained. A done column never blocks the others.
//  Move latency: first valid move appears 3 cycles after SCAN sees non-empty (rden, WAIT, UNPACK).
//  move_valid registered; a valid&ready accept may advance to the next valid slot in the same cycle (back-to-back, 1 move/cycle).
// STRUCTURE
//  chess_move_pkg holds shared constants:
//   - MOVE_W, flag bit indices: FLG_INVALID=18 ... FLG_CAPTURE=12
//   - FROM/TO field ranges
//   - SLOTS, WORD_W
//  One sub-module, move_unpacker:
//   - holds word_r and the slot iterator
//   - ports: load, word, move_out/valid/ready, last
//  Top level keeps the round-robin scan FSM and the counters.
// TESTING
//  1. Reset mid-UNPACK (move_valid=1) -> next cycle valid=0, count=0, rden=0, state SCAN.
//  2. Col 3 has one word, slots 0,2 valid (0x0_0C1C, 0x0_0820), rest invalid, ready=1.
//     -> rden[3] pulses once; moves 0x00C1C then 0x00820 on consecutive cycles; count=2.
//  3. Cols 0,5,7 non-empty, rr_ptr=6 -> service order 7,0,5; each rden is one-hot and a single cycle.
//  4. move_ready held low 10 cycles with valid=1 -> move_out constant; no count change; no new rden.
//  5. col_done=8'hFF with col_empty[2]=0 -> col 2 drained first; done rises 2 SCAN cycles after last accept+empty.
//  6. All-invalid word (bit18 set in all slots) -> no move_valid; back in SCAN 1 cycle after WAIT.
//     300 valid moves total -> move_count=255.

Source files
------------

// File: rtl/board_move_collector_pkg.sv
// Shared move/word layout constants, FSM state type and small selection helpers
// for the column move collector.
package board_move_collector_pkg;

  localparam int NCOL        = 8;
  localparam int WORD_W      = 160;
  localparam int MOVE_W      = 19;
  localparam int SLOTS       = 8;
  localparam int FLG_INVALID = 18;

  // Bit layout of one 19-bit move, MSB first.
  typedef struct packed {
    logic       invalid;
    logic       promote;
    logic       pawn;
    logic       pawn2;
    logic       ep;
    logic       castle;
    logic       capture;
    logic [5:0] from;
    logic [5:0] to;
  } move_t;

  typedef enum logic [2:0] {
    ST_SCAN,
    ST_READ,
    ST_WAIT,
    ST_UNPACK,
    ST_DONE
  } state_t;

  function automatic logic [2:0] first_set(input logic [7:0] m);
    first_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) first_set = 3'(i);
    end
  endfunction

  // Lowest requesting index at or after ptr, wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] req);
    logic [7:0] rot;
    rot = (req >> ptr) | (req << (4'd8 - {1'b0, ptr}));
    rr_pick = ptr + first_set(rot);
  endfunction

endpackage

// File: rtl/board_move_collector_unpacker.sv
// Holds one FIFO word and walks its valid slots; move_valid/move_out are registered
// and an accept may load the next valid slot in the same cycle (1 move/cycle).
module board_move_collector_unpacker
  import board_move_collector_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [SLOTS*MOVE_W-1:0] word,
  output logic [MOVE_W-1:0]       move_out,
  output logic                    move_valid,
  input  logic                    move_ready,
  output logic                    last
);

  logic [SLOTS*MOVE_W-1:0] word_r;
  logic [SLOTS-1:0]        pend_r;
  logic [SLOTS-1:0]        load_mask;
  logic [2:0]              load_idx;
  logic [2:0]              pend_idx;

  always_comb begin
    load_mask = '0;
    for (int k = 0; k < SLOTS; k++) begin
      load_mask[k] = ~word[k*MOVE_W + FLG_INVALID];
    end
  end

  assign load_idx = first_set(load_mask);
  assign pend_idx = first_set(pend_r);

  // High in the cycle that finishes the word: nothing left pending and no move stuck.
  assign last = (~move_valid | move_ready) & ~(|pend_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      word_r     <= '0;
      pend_r     <= '0;
      move_out   <= '0;
      move_valid <= 1'b0;
    end else if (load) begin
      word_r     <= word;
      move_valid <= |load_mask;
      move_out   <= word[load_idx*MOVE_W +: MOVE_W];
      pend_r     <= load_mask & ~(SLOTS'(1) << load_idx);
    end else if (move_valid && move_ready) begin
      move_valid <= |pend_r;
      if (|pend_r) begin
        move_out <= word_r[pend_idx*MOVE_W +: MOVE_W];
      end
      pend_r <= pend_r & ~(SLOTS'(1) << pend_idx);
    end
  end

endmodule

// File: rtl/board_move_collector.sv
// Round-robin drain of the column move FIFOs into a single move stream; first move
// 3 cycles after a non-empty column is seen, stalls on move_ready with no new reads.
module board_move_collector
  import board_move_collector_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCOL-1:0]          col_done,
  input  logic [NCOL-1:0]          col_empty,
  input  logic [NCOL*WORD_W-1:0]   col_data,
  output logic [NCOL-1:0]          col_rden,
  output logic [MOVE_W-1:0]        move_out,
  output logic                     move_valid,
  input  logic                     move_ready,
  output logic [7:0]               move_count,
  output logic                     done
);

  state_t                  state;
  logic [2:0]              rr_ptr;
  logic [2:0]              sel;
  logic [2:0]              pick;
  logic                    idle_seen;
  logic                    last;
  logic [SLOTS*MOVE_W-1:0] sel_word;

  assign pick     = rr_pick(rr_ptr, ~col_empty);
  assign sel_word = col_data[sel*WORD_W +: SLOTS*MOVE_W];

  board_move_collector_unpacker u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .load       (state == ST_WAIT),
    .word       (sel_word),
    .move_out   (move_out),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_SCAN;
      rr_ptr     <= '0;
      sel        <= '0;
      col_rden   <= '0;
      idle_seen  <= 1'b0;
      move_count <= '0;
      done       <= 1'b0;
    end else begin
      if (move_valid && move_ready && move_count != 8'hFF) begin
        move_count <= move_count + 8'd1;
      end
      case (state)
        ST_SCAN: begin
          if (~&col_empty) begin
            sel       <= pick;
            col_rden  <= NCOL'(1) << pick;
            idle_seen <= 1'b0;
            state     <= ST_READ;
          end else if (&col_done) begin
            // Two idle passes in a row absorb the column's registered write lag.
            if (idle_seen) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
            idle_seen <= 1'b1;
          end else begin
            idle_seen <= 1'b0;
          end
        end
        ST_READ: begin
          col_rden <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          state <= ST_UNPACK;
        end
        ST_UNPACK: begin
          if (last) begin
            rr_ptr <= sel + 3'd1;
            state  <= ST_SCAN;
          end
        end
        ST_DONE: begin
          col_rden <= '0;
          done     <= 1'b1;
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_board_move_collector.sv
// Randomised bench for board_move_collector: emulated non-show-ahead FIFOs and a
// transaction-level round-robin model supply the expected move and read order.
module tb_board_move_collector;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     col_done;
  logic [7:0]     col_empty = 8'hFF;
  logic [1279:0]  col_data;
  logic [7:0]     col_rden;
  logic [18:0]    move_out;
  logic           move_valid;
  logic           move_ready;
  logic [7:0]     move_count;
  logic           done;

  board_move_collector dut (
    .clk        (clk),
    .reset      (reset),
    .col_done   (col_done),
    .col_empty  (col_empty),
    .col_data   (col_data),
    .col_rden   (col_rden),
    .move_out   (move_out),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_count (move_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int total = 0;
  int mptr = 0;
  int done_cyc = -1;

  logic [159:0] fq [8][$];
  logic [159:0] mq [8][$];
  logic [159:0] qd [8];
  logic [18:0]  got_moves[$];
  logic [18:0]  exp_moves[$];
  int           got_rden[$];
  int           exp_rden[$];
  int           rden_cyc[$];
  int           acc_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Non-show-ahead FIFOs: data appears the cycle after the read request.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < 8; c++) begin
      if (col_rden[c] && fq[c].size() > 0) qd[c] <= fq[c].pop_front();
      col_empty[c] <= (fq[c].size() == 0);
    end
  end

  always_comb begin
    col_data = '0;
    for (int c = 0; c < 8; c++) col_data[c*160 +: 160] = qd[c];
  end

  logic        p_hold = 1'b0;
  logic [18:0] p_out;
  logic [7:0]  p_cnt;
  logic [7:0]  p_rden = '0;
  logic        p_done = 1'b0;
  int          ridx;

  always @(negedge clk) begin
    if (!reset) begin
      if (move_valid && move_ready) begin
        got_moves.push_back(move_out);
        acc_cyc.push_back(cyc);
      end
      if (col_rden != 8'h00) begin
        ridx = 0;
        for (int c = 0; c < 8; c++) if (col_rden[c]) ridx = c;
        check("rden_onehot", $countones(col_rden), 1);
        check("rden_when_empty", col_rden & col_empty, 0);
        check("rden_single_cycle", p_rden, 0);
        got_rden.push_back(ridx);
        rden_cyc.push_back(cyc);
      end
      if (p_hold) begin
        check("hold_valid", move_valid, 1);
        check("hold_data", move_out, p_out);
        check("hold_count", move_count, p_cnt);
      end
      if (done && !p_done) done_cyc = cyc;
    end
    p_hold = !reset && move_valid && !move_ready;
    p_out  = move_out;
    p_cnt  = move_count;
    p_rden = reset ? 8'h00 : col_rden;
    p_done = done;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] gen_word(input int pct);
    logic [159:0] w;
    logic [18:0]  m;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 8; k++) begin
      m = 19'($urandom);
      m[18] = ($urandom_range(0, 99) >= pct);
      w[k*19 +: 19] = m;
    end
    return w;
  endfunction

  task automatic load(input int c, input logic [159:0] w, input bit model = 1'b1);
    fq[c].push_back(w);
    if (model) mq[c].push_back(w);
  endtask

  // Whole-word service order: first non-empty column from the pointer, then pointer = c+1.
  task automatic run_model();
    int c;
    logic [159:0] w;
    logic [18:0]  m;
    forever begin
      c = -1;
      for (int i = 0; i < 8; i++) begin
        if (c < 0 && mq[(mptr + i) % 8].size() > 0) c = (mptr + i) % 8;
      end
      if (c < 0) break;
      w = mq[c].pop_front();
      exp_rden.push_back(c);
      for (int k = 0; k < 8; k++) begin
        m = w[k*19 +: 19];
        if (!m[18]) begin
          exp_moves.push_back(m);
          total++;
        end
      end
      mptr = (c + 1) % 8;
    end
  endtask

  task automatic clear_obs();
    got_moves.delete(); exp_moves.delete();
    got_rden.delete();  exp_rden.delete();
    rden_cyc.delete();  acc_cyc.delete();
  endtask

  task automatic drain(input bit rnd);
    int t = 0;
    run_model();
    while ((got_moves.size() < exp_moves.size() || got_rden.size() < exp_rden.size()) && t < 2000) begin
      if (rnd) move_ready = ($urandom_range(0, 3) != 0);
      tick(1);
      t++;
    end
    check("drain_budget", t < 2000, 1);
    move_ready = 1'b1;
    tick(6);
    check("rden_total", got_rden.size(), exp_rden.size());
    for (int i = 0; i < exp_rden.size() && i < got_rden.size(); i++)
      check("rden_column", got_rden[i], exp_rden[i]);
    check("move_total", got_moves.size(), exp_moves.size());
    for (int i = 0; i < exp_moves.size() && i < got_moves.size(); i++)
      check("move_value", got_moves[i], exp_moves[i]);
    check("move_count", move_count, (total > 255) ? 255 : total);
  endtask

  initial begin
    logic [159:0] w;
    logic [18:0]  held;
    logic [7:0]   held_cnt;
    int           nr;
    int           t;

    reset = 1'b1; col_done = 8'h00; move_ready = 1'b0;
    tick(3);
    check("reset_rden", col_rden, 0);
    check("reset_valid", move_valid, 0);
    check("reset_move_out", move_out, 0);
    check("reset_count", move_count, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    tick(2);

    // Column 3: slots 0 and 2 valid, accepted back to back.
    clear_obs();
    move_ready = 1'b1;
    w = gen_word(0);
    w[0 +: 19]  = 19'h00C1C;
    w[38 +: 19] = 19'h00820;
    load(3, w);
    drain(1'b0);
    check("t2_rden_col", got_rden.size() > 0 ? got_rden[0] : -1, 3);
    check("t2_back_to_back", acc_cyc.size() == 2 ? acc_cyc[1] - acc_cyc[0] : -1, 1);

    // Move the pointer to 6, then columns 0, 5, 7 must be served 7, 0, 5.
    clear_obs();
    load(5, gen_word(60));
    drain(1'b1);
    clear_obs();
    load(0, gen_word(60)); load(5, gen_word(60)); load(7, gen_word(60));
    drain(1'b1);
    check("t3_order0", got_rden.size() > 0 ? got_rden[0] : -1, 7);
    check("t3_order1", got_rden.size() > 1 ? got_rden[1] : -1, 0);
    check("t3_order2", got_rden.size() > 2 ? got_rden[2] : -1, 5);

    // Consumer stalls for 10 cycles with a move pending.
    clear_obs();
    move_ready = 1'b0;
    load(1, gen_word(100));
    run_model();
    t = 0;
    while (!move_valid && t < 20) begin tick(1); t++; end
    check("t4_valid_budget", t < 20, 1);
    held = move_out; held_cnt = move_count; nr = got_rden.size();
    check("t4_first_move", held, exp_moves.size() > 0 ? exp_moves[0] : 19'h0);
    tick(10);
    check("t4_still_valid", move_valid, 1);
    check("t4_move_stable", move_out, held);
    check("t4_count_stable", move_count, held_cnt);
    check("t4_no_new_rden", got_rden.size(), nr);
    drain(1'b1);

    // All-invalid word costs one UNPACK cycle: next read follows 4 cycles later.
    clear_obs();
    move_ready = 1'b1;
    nr = mptr;
    load(nr, gen_word(0));
    load((nr + 1) % 8, gen_word(70));
    drain(1'b0);
    check("t6_rden_gap", rden_cyc.size() >= 2 ? rden_cyc[1] - rden_cyc[0] : -1, 4);

    // Bulk random traffic past 255 moves to reach the count ceiling.
    for (int r = 0; r < 100 && total < 300; r++) begin
      clear_obs();
      repeat ($urandom_range(1, 4)) load($urandom_range(0, 7), gen_word($urandom_range(30, 100)));
      drain(1'b1);
    end
    check("t5_count_saturated", move_count, 255);

    // All columns done while column 2 still holds data.
    clear_obs();
    done_cyc = -1;
    w = gen_word(80);
    w[18] = 1'b0;
    col_done = 8'hFF;
    load(2, w);
    load(2, gen_word(50));
    drain(1'b1);
    t = 0;
    while (!done && t < 20) begin tick(1); t++; end
    check("t7_done", done, 1);
    check("t7_col2_first", got_rden.size() > 0 ? got_rden[0] : -1, 2);
    check("t7_done_lag", acc_cyc.size() > 0 ? done_cyc - acc_cyc[acc_cyc.size()-1] : -1, 3);
    nr = got_rden.size();
    load(4, gen_word(100), 1'b0);
    tick(10);
    check("t7_done_sticky", done, 1);
    check("t7_done_no_rden", got_rden.size(), nr);
    check("t7_done_no_valid", move_valid, 0);

    // Reset while a move is presented.
    reset = 1'b1; tick(1); reset = 1'b0;
    col_done = 8'h00; move_ready = 1'b0;
    t = 0;
    while (!move_valid && t < 20) begin tick(1); t++; end
    check("t1_valid_before_reset", move_valid, 1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("t1_valid", move_valid, 0);
    check("t1_count", move_count, 0);
    check("t1_rden", col_rden, 0);
    check("t1_move_out", move_out, 0);
    check("t1_done", done, 0);
    reset = 1'b0;
    mptr = 0; total = 0;
    for (int c = 0; c < 8; c++) mq[c].delete();
    tick(2);
    clear_obs();
    load(6, gen_word(60)); load(1, gen_word(60));
    drain(1'b1);
    check("t1_ptr_restart", got_rden.size() > 0 ? got_rden[0] : -1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
